// File: rtl/prio_int_ctrl.sv
// -----------------------------------------------------------------------------
// prio_int_ctrl
// Nesting priority interrupt controller. Rising edges on irq set pending bits.
// The highest-level, enabled, pending source whose level is above the level
// currently in service raises intr. An acknowledge pushes the current level
// onto a small stack. A return pops it again.
//
// Ports
//   CLK         in   clock, all state changes on the rising edge
//   Reset       in   synchronous active-high reset
//   irq         in   [N_IRQ]   rising-edge request lines
//   intWrite    in   config register write strobe
//   intAddr     in   [2]       register select (0 MASK, 1 PEND, 2 LVL, 3 STATUS)
//   intDataIn   in   [W]       config write data
//   intAck      in   CPU acknowledge pulse
//   intRet      in   CPU return-from-interrupt pulse
//   intr        out  registered interrupt request
//   intVec      out  [VW]      index of the last acknowledged source
//   intDataOut  out  [W]       registered read data for intAddr
// -----------------------------------------------------------------------------
module prio_int_ctrl #(
   parameter int N_IRQ = 4,
   parameter int LVL_W = 2,
   parameter int W     = 16,
   localparam int VW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [N_IRQ-1:0] irq,
   input  logic             intWrite,
   input  logic [1:0]       intAddr,
   input  logic [W-1:0]     intDataIn,
   input  logic             intAck,
   input  logic             intRet,
   output logic             intr,
   output logic [VW-1:0]    intVec,
   output logic [W-1:0]     intDataOut
);

   localparam int LW  = N_IRQ * LVL_W;
   // Stack sized to the full index range of the depth counter. Depth never
   // exceeds 2^LVL_W-1 because pushed levels strictly increase.
   localparam int STK = 2 ** LVL_W;

   typedef enum logic [0:0] {IDLE = 1'b0, NEST = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [N_IRQ-1:0]   mask_q, mask_d;
   logic [N_IRQ-1:0]   pend_q, pend_d;
   logic [LW-1:0]      lvl_q, lvl_d;
   logic [LVL_W-1:0]   cur_q, cur_d;
   logic [LVL_W-1:0]   depth_q, depth_d;
   logic               err_q, err_d;
   logic [N_IRQ-1:0]   irq_prev_q;
   logic               intr_q, intr_d;
   logic [VW-1:0]      vec_q, vec_d;
   logic [W-1:0]       dout_q, dout_d;
   logic [LVL_W-1:0]   stack_q [STK];

   logic               any_cand_s;
   logic [VW-1:0]      win_idx_s;
   logic [LVL_W-1:0]   win_lvl_s;
   logic               ack_s;
   logic               pop_s;
   logic [N_IRQ-1:0]   pend_clr_s;
   logic [W-1:0]       rdata_s;
   logic               unused_data_s;

   // Only the low bits of the write data reach a register.
   assign unused_data_s = ^intDataIn;

   // Winner search: strictly greater level replaces the current pick, so ties
   // keep the lowest index.
   always_comb begin
      any_cand_s = 1'b0;
      win_idx_s  = '0;
      win_lvl_s  = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         logic [LVL_W-1:0] l;
         logic             cand;
         logic             take;
         l          = lvl_q[i*LVL_W +: LVL_W];
         cand       = pend_q[i] & mask_q[i] & (l > cur_q);
         take       = cand & (~any_cand_s | (l > win_lvl_s));
         any_cand_s = any_cand_s | take;
         win_idx_s  = take ? VW'(i) : win_idx_s;
         win_lvl_s  = take ? l : win_lvl_s;
      end
   end

   // A return takes precedence over an acknowledge. An ack with no surviving
   // candidate (e.g. pending bit cleared in between) is dropped.
   assign ack_s = intAck & intr_q & ~intRet & any_cand_s;
   assign pop_s = intRet & (state_q == NEST);

   // Register read mux; unused upper bits stay zero.
   always_comb begin
      rdata_s = '0;
      case (intAddr)
         2'd0: rdata_s[N_IRQ-1:0] = mask_q;
         2'd1: rdata_s[N_IRQ-1:0] = pend_q;
         2'd2: rdata_s[LW-1:0]    = lvl_q;
         2'd3: begin
            rdata_s[W-1]               = err_q;
            rdata_s[2*LVL_W-1:LVL_W]   = depth_q;
            rdata_s[LVL_W-1:0]         = cur_q;
         end
         default: rdata_s = '0;
      endcase
   end

   // Next-state for configuration, pending bits, nesting and outputs.
   always_comb begin
      mask_d     = mask_q;
      lvl_d      = lvl_q;
      pend_clr_s = '0;
      case ({intWrite, intAddr})
         3'b100:  mask_d     = intDataIn[N_IRQ-1:0];
         3'b101:  pend_clr_s = intDataIn[N_IRQ-1:0];
         3'b110:  lvl_d      = intDataIn[LW-1:0];
         default: pend_clr_s = '0;
      endcase
      pend_clr_s = pend_clr_s | (ack_s ? (N_IRQ'(1) << win_idx_s) : N_IRQ'(0));
      // New edges are ORed in last so a set beats a same-cycle clear.
      pend_d = (pend_q & ~pend_clr_s) | (irq & ~irq_prev_q);

      cur_d   = cur_q;
      depth_d = depth_q;
      err_d   = err_q;
      vec_d   = vec_q;
      if (pop_s) begin
         cur_d   = stack_q[depth_q - LVL_W'(1)];
         depth_d = depth_q - LVL_W'(1);
      end else if (intRet) begin
         err_d = 1'b1;
      end else if (ack_s) begin
         cur_d   = win_lvl_s;
         depth_d = depth_q + LVL_W'(1);
         vec_d   = win_idx_s;
      end else begin
         cur_d = cur_q;
      end

      // The acked winner becomes curLvl, so nothing else can qualify next cycle.
      intr_d = any_cand_s & ~ack_s;
      dout_d = rdata_s;
   end

   // Nesting FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = ack_s ? NEST : IDLE;
         NEST:    state_d = (pop_s && (depth_q == LVL_W'(1))) ? IDLE : NEST;
         default: state_d = IDLE;
      endcase
   end

   // State registers. During reset the irq history follows the pins so a line
   // held high through reset does not look like a fresh edge afterwards.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q    <= IDLE;
         mask_q     <= '0;
         pend_q     <= '0;
         lvl_q      <= '0;
         cur_q      <= '0;
         depth_q    <= '0;
         err_q      <= 1'b0;
         irq_prev_q <= irq;
         intr_q     <= 1'b0;
         vec_q      <= '0;
         dout_q     <= '0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         pend_q     <= pend_d;
         lvl_q      <= lvl_d;
         cur_q      <= cur_d;
         depth_q    <= depth_d;
         err_q      <= err_d;
         irq_prev_q <= irq;
         intr_q     <= intr_d;
         vec_q      <= vec_d;
         dout_q     <= dout_d;
      end
   end

   // Level stack: push the interrupted level on an accepted ack.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         for (int i = 0; i < STK; i++) begin
            stack_q[i] <= '0;
         end
      end else if (ack_s) begin
         stack_q[depth_q] <= cur_q;
      end
   end

   assign intr       = intr_q;
   assign intVec     = vec_q;
   assign intDataOut = dout_q;

endmodule
